// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle HI/LO multiply/divide unit.
//
// Ports:
//   clk     in   1   single clock, rising edge
//   reset   in   1   synchronous active-high reset
//   start   in   1   new operation this cycle (mdu_op/inputA/inputB valid)
//   mdu_op  in   3   000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
//   inputA  in   32  rs operand / dividend / MTHI-MTLO source
//   inputB  in   32  rt operand / divisor
//   flush   in   1   abort any in-flight operation
//   busy    out  1   registered, high while count != 0
//   hi, lo  out  32  HI/LO registers
//
// Operands are latched on acceptance and the result is computed from the
// latched copies on the completion edge, so the cycle count is purely a
// latency model.
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] inputA,
    input  logic [31:0] inputB,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpMult  = 3'd1,
        OpMultu = 3'd2,
        OpDiv   = 3'd3,
        OpDivu  = 3'd4,
        OpMthi  = 3'd5,
        OpMtlo  = 3'd6,
        OpRsvd  = 3'd7
    } mdu_op_e;

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [CntW-1:0] count_q, count_d;
    mdu_op_e         op_q, op_d;
    logic [31:0]     a_q, a_d, b_q, b_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic            busy_q;

    // Datapath on latched operands
    logic [63:0] smul, umul;
    logic [31:0] a_mag, b_mag, uquot, urem, squot_mag, srem_mag, squot, srem;
    logic        div_ok;

    always_comb begin
        smul      = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        umul      = {32'd0, a_q} * {32'd0, b_q};
        div_ok    = (b_q != 32'd0);
        uquot     = a_q / b_q;
        urem      = a_q % b_q;
        // Magnitude-based signed divide: 0x80000000 is 2^31 as an unsigned
        // magnitude, so 0x80000000 / -1 naturally wraps to 0x80000000 rem 0.
        a_mag     = a_q[31] ? -a_q : a_q;
        b_mag     = b_q[31] ? -b_q : b_q;
        squot_mag = a_mag / b_mag;
        srem_mag  = a_mag % b_mag;
        squot     = (a_q[31] ^ b_q[31]) ? -squot_mag : squot_mag;
        srem      = a_q[31] ? -srem_mag : srem_mag;
    end

    always_comb begin
        count_d = count_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush) begin
            count_d = '0;
        end else if (count_q != '0) begin
            count_d = count_q - CntW'(1);
            if (count_q == CntW'(1)) begin
                case (op_q)
                    OpMult:  {hi_d, lo_d} = smul;
                    OpMultu: {hi_d, lo_d} = umul;
                    OpDiv:   if (div_ok) {hi_d, lo_d} = {srem, squot};
                    OpDivu:  if (div_ok) {hi_d, lo_d} = {urem, uquot};
                    default: ;
                endcase
            end
        end else if (start) begin
            case (mdu_op_e'(mdu_op))
                OpMult, OpMultu: begin
                    op_d    = mdu_op_e'(mdu_op);
                    a_d     = inputA;
                    b_d     = inputB;
                    count_d = CntW'(MULT_CYCLES);
                end
                OpDiv, OpDivu: begin
                    op_d    = mdu_op_e'(mdu_op);
                    a_d     = inputA;
                    b_d     = inputB;
                    count_d = CntW'(DIV_CYCLES);
                end
                OpMthi:  hi_d = inputA;
                OpMtlo:  lo_d = inputA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            op_q    <= OpNone;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (count_d != '0);
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table plus directed
// sequences for flush, reset and back-to-back corner cases.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  mdu_op;
    logic [31:0] inputA, inputB;
    logic        busy;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .inputA (inputA),
        .inputB (inputB),
        .flush  (flush),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op, scramble operands after acceptance, count busy cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        start  = 1'b1;
        mdu_op = op;
        inputA = a;
        inputB = b;
        step();
        start  = 1'b0;
        mdu_op = 3'd0;
        inputA = $urandom;
        inputB = $urandom;
        n = 0;
        while (busy && n < 50) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;

        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'h00000003, 5,  32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd4, 32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
        vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[5]  = '{3'd5, 32'h12345678, 32'h0,        0,  32'h12345678, 32'h80000000};
        vecs[6]  = '{3'd4, 32'h00000005, 32'h0,        10, 32'h12345678, 32'h80000000};
        vecs[7]  = '{3'd3, 32'h00000007, 32'h0,        10, 32'h12345678, 32'h80000000};
        vecs[8]  = '{3'd6, 32'hCAFEBABE, 32'h0,        0,  32'h12345678, 32'hCAFEBABE};
        vecs[9]  = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001};
        vecs[10] = '{3'd1, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
        vecs[11] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[12] = '{3'd4, 32'hFFFFFFFF, 32'h00000010, 10, 32'h0000000F, 32'h0FFFFFFF};
        vecs[13] = '{3'd0, 32'hDEADBEEF, 32'h1,        0,  32'h0000000F, 32'h0FFFFFFF};
        vecs[14] = '{3'd7, 32'hDEADBEEF, 32'h1,        0,  32'h0000000F, 32'h0FFFFFFF};
        vecs[15] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        mdu_op = 3'd0; inputA = '0; inputB = '0;
        step();
        step();
        reset = 1'b0;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            check($sformatf("vec%0d_cycles", i), n, vecs[i].cycles);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
        end

        // Flush on 3rd busy cycle, with a second start during busy ignored.
        run_op(3'd5, 32'hAAAA0000, 32'h0, n);
        run_op(3'd6, 32'h0000BBBB, 32'h0, n);
        start = 1'b1; mdu_op = 3'd1; inputA = 32'd3; inputB = 32'd4;
        step();
        check("flush_busy_c1", {31'd0, busy}, 32'd1);
        mdu_op = 3'd2; inputA = 32'd5; inputB = 32'd6;
        step();
        start = 1'b0; mdu_op = 3'd0;
        check("flush_busy_c3", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy_after", {31'd0, busy}, 32'd0);
        check("flush_hi", hi, 32'hAAAA0000);
        check("flush_lo", lo, 32'h0000BBBB);
        for (int i = 0; i < 8; i++) step();
        check("flush_busy_later", {31'd0, busy}, 32'd0);
        check("flush_hi_later", hi, 32'hAAAA0000);
        check("flush_lo_later", lo, 32'h0000BBBB);

        // Flush on the completion edge wins over the HI/LO write.
        start = 1'b1; mdu_op = 3'd4; inputA = 32'd9; inputB = 32'd2;
        step();
        start = 1'b0; mdu_op = 3'd0;
        for (int i = 0; i < 9; i++) step();
        check("cflush_busy_c10", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("cflush_busy", {31'd0, busy}, 32'd0);
        check("cflush_hi", hi, 32'hAAAA0000);
        check("cflush_lo", lo, 32'h0000BBBB);

        // Flush coincident with MTHI suppresses it.
        start = 1'b1; mdu_op = 3'd5; inputA = 32'hDEAD0001; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0; mdu_op = 3'd0;
        check("flush_mthi_hi", hi, 32'hAAAA0000);

        // Reset during DIV at count=4 aborts with HI/LO cleared.
        start = 1'b1; mdu_op = 3'd3; inputA = 32'd100; inputB = 32'd7;
        step();
        start = 1'b0; mdu_op = 3'd0;
        for (int i = 0; i < 6; i++) step();
        check("rst_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        for (int i = 0; i < 6; i++) step();
        check("rst_no_late_write", lo, 32'h0);
        start = 1'b1; mdu_op = 3'd6; inputA = 32'h00001234; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0; mdu_op = 3'd0;
        check("flush_mtlo_lo", lo, 32'h0);

        // Reset takes priority over a coincident start.
        start = 1'b1; mdu_op = 3'd5; inputA = 32'h55555555; reset = 1'b1;
        step();
        start = 1'b0; reset = 1'b0; mdu_op = 3'd0;
        check("rst_over_start_hi", hi, 32'h0);

        // Back-to-back: second start driven on the first idle cycle.
        run_op(3'd1, 32'd2, 32'd3, n);
        check("b2b_first_cycles", n, 32'd5);
        check("b2b_first_lo", lo, 32'd6);
        check("b2b_first_hi", hi, 32'd0);
        run_op(3'd1, 32'd4, 32'hFFFFFFFB, n);
        check("b2b_second_cycles", n, 32'd5);
        check("b2b_second_lo", lo, 32'hFFFFFFEC);
        check("b2b_second_hi", hi, 32'hFFFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
